// File: rtl/id_hazard_grf_pkg.sv
// Shared widths, forward-select encoding and scoreboard slot layout for the
// decode-stage register file / hazard unit.
package id_hazard_grf_pkg;

  localparam int XLEN          = 32;
  localparam int NREG          = 32;
  localparam int AW            = $clog2(NREG);
  localparam int DEPTH         = 3;
  localparam int FW            = $clog2(DEPTH + 1);
  localparam int TW            = 3;
  localparam int DEF_MULT_LAT  = 5;
  localparam int DEF_DIV_LAT   = 10;

  localparam logic [FW-1:0] FWD_NONE = '0;

  typedef struct packed {
    logic          valid;
    logic          wr;
    logic [AW-1:0] a3;
    logic [TW-1:0] tnew;
  } slot_t;

  // Tnew counts down as an instruction moves one stage deeper, never below zero.
  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

endpackage

// File: rtl/id_hazard_grf_if.sv
// Decode-stage bundle: instruction descriptor from the controller, W write-back
// port, and the read values / hazard decisions returned to the pipeline.
interface id_hazard_grf_if;
  import id_hazard_grf_pkg::*;

  logic            d_valid;
  logic [AW-1:0]   d_rs;
  logic [AW-1:0]   d_rt;
  logic [TW-1:0]   d_tuse_rs;
  logic [TW-1:0]   d_tuse_rt;
  logic            d_regwrite;
  logic [AW-1:0]   d_a3;
  logic [TW-1:0]   d_tnew;
  logic            d_md;
  logic            d_md_div;
  logic            d_mfmt;
  logic            flush;
  logic            w_regwrite;
  logic [AW-1:0]   w_a3;
  logic [XLEN-1:0] w_wd;
  logic [XLEN-1:0] rs_value;
  logic [XLEN-1:0] rt_value;
  logic [FW-1:0]   fwd_rs_sel;
  logic [FW-1:0]   fwd_rt_sel;
  logic            stall;
  logic            md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regwrite, d_a3, d_tnew,
           d_md, d_md_div, d_mfmt, flush, w_regwrite, w_a3, w_wd,
    input  rs_value, rt_value, fwd_rs_sel, fwd_rt_sel, stall, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regwrite, d_a3, d_tnew,
           d_md, d_md_div, d_mfmt, flush, w_regwrite, w_a3, w_wd,
    output rs_value, rt_value, fwd_rs_sel, fwd_rt_sel, stall, md_busy
  );

endinterface

// File: rtl/id_hazard_grf_bypass.sv
// General register file: two combinational read ports, one write port, r0 fixed
// at zero, and a same-cycle write-first bypass from the W stage.
module grf_bypass
  import id_hazard_grf_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rd_a1,
  input  logic [AW-1:0]   rd_a2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd_d1,
  output logic [XLEN-1:0] rd_d2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  // A write landing this cycle is visible to D immediately, so W never needs a forward path.
  assign rd_d1 = (rd_a1 == '0) ? '0 : (we && wa == rd_a1) ? wd : regs[rd_a1];
  assign rd_d2 = (rd_a2 == '0) ? '0 : (we && wa == rd_a2) ? wd : regs[rd_a2];

endmodule

// File: rtl/id_hazard_grf.sv
// Decode-stage register file plus Tnew/Tuse hazard scoreboard and mult/div busy
// tracking; produces stall and D-stage forward selects.
module id_hazard_grf
  import id_hazard_grf_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input logic            clk,
  input logic            reset,
  id_hazard_grf_if.slave bus
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int MW      = $clog2(MAX_LAT + 1);

  slot_t         slots [DEPTH];
  logic [MW-1:0] md_cnt;
  logic          md_busy;
  logic          stall_rs;
  logic          stall_rt;
  logic          stall_md;
  logic          stall;
  logic          issue;
  logic [FW-1:0] fwd_rs;
  logic [FW-1:0] fwd_rt;

  grf_bypass u_grf (
    .clk   (clk),
    .reset (reset),
    .rd_a1 (bus.d_rs),
    .rd_a2 (bus.d_rt),
    .we    (bus.w_regwrite),
    .wa    (bus.w_a3),
    .wd    (bus.w_wd),
    .rd_d1 (bus.rs_value),
    .rd_d2 (bus.rt_value)
  );

  // Scan oldest to youngest so the youngest matching producer has the final say.
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    fwd_rs   = FWD_NONE;
    fwd_rt   = FWD_NONE;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slots[k].valid && slots[k].wr && bus.d_rs != '0 && slots[k].a3 == bus.d_rs) begin
        stall_rs = slots[k].tnew > bus.d_tuse_rs;
        fwd_rs   = (slots[k].tnew == '0) ? FW'(k + 1) : FWD_NONE;
      end
      if (slots[k].valid && slots[k].wr && bus.d_rt != '0 && slots[k].a3 == bus.d_rt) begin
        stall_rt = slots[k].tnew > bus.d_tuse_rt;
        fwd_rt   = (slots[k].tnew == '0) ? FW'(k + 1) : FWD_NONE;
      end
    end
  end

  assign md_busy  = (md_cnt != '0);
  assign stall_md = bus.d_valid & (bus.d_md | bus.d_mfmt) & md_busy;
  assign stall    = bus.d_valid & ~bus.flush & (stall_rs | stall_rt | stall_md);
  assign issue    = bus.d_valid & ~stall & ~bus.flush;

  // Slots advance every cycle; a stalled or empty D stage injects an invalid bubble into E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) slots[k] <= '0;
      md_cnt <= '0;
    end else if (bus.flush) begin
      for (int k = 0; k < DEPTH; k++) slots[k] <= '0;
      md_cnt <= '0;
    end else begin
      slots[0] <= issue ? {1'b1, (bus.d_regwrite && bus.d_a3 != '0), bus.d_a3, bus.d_tnew}
                        : '0;
      for (int k = 1; k < DEPTH; k++) begin
        slots[k] <= {slots[k-1].valid, slots[k-1].wr, slots[k-1].a3, tnew_dec(slots[k-1].tnew)};
      end
      if (issue && bus.d_md) begin
        md_cnt <= bus.d_md_div ? MW'(DIV_LAT) : MW'(MULT_LAT);
      end else if (md_busy) begin
        md_cnt <= md_cnt - 1'b1;
      end
    end
  end

  assign bus.stall      = stall;
  assign bus.md_busy    = md_busy;
  assign bus.fwd_rs_sel = fwd_rs;
  assign bus.fwd_rt_sel = fwd_rt;

endmodule

// File: tb/tb_id_hazard_grf.sv
// Directed and randomized bench for id_hazard_grf against an age-based
// reference model of the register file, in-flight producers and mult/div unit.
module tb_id_hazard_grf;
  import id_hazard_grf_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_hazard_grf_if bus ();

  id_hazard_grf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: producers are kept by age with their issue-time Tnew,
  // and mult/div busy is the cycle number at which the unit becomes free.
  logic [31:0] m_regs [32];
  logic        m_valid [3];
  logic        m_wr [3];
  logic [4:0]  m_a3 [3];
  int          m_t0 [3];
  int          cyc = 0;
  int          md_ready = 0;

  logic [31:0] e_rs_val, e_rt_val;
  int          e_fwd_rs, e_fwd_rt;
  logic        e_stall, e_busy, e_issue;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.w_regwrite && bus.w_a3 == a) return bus.w_wd;
    return m_regs[a];
  endfunction

  task automatic model_lookup(input logic [4:0] r, input int tuse, output logic st, output int fw);
    logic found;
    int   tn;
    st = 1'b0;
    fw = 0;
    found = 1'b0;
    for (int age = 0; age < 3; age++) begin
      if (!found && r != 5'd0 && m_valid[age] && m_wr[age] && m_a3[age] == r) begin
        found = 1'b1;
        tn = (m_t0[age] > age) ? m_t0[age] - age : 0;
        st = (tn > tuse);
        fw = (tn == 0) ? age + 1 : 0;
      end
    end
  endtask

  task automatic model_eval();
    logic srs, srt;
    e_rs_val = model_read(bus.d_rs);
    e_rt_val = model_read(bus.d_rt);
    model_lookup(bus.d_rs, int'(bus.d_tuse_rs), srs, e_fwd_rs);
    model_lookup(bus.d_rt, int'(bus.d_tuse_rt), srt, e_fwd_rt);
    e_busy  = (cyc < md_ready);
    e_stall = bus.d_valid && !bus.flush && (srs || srt || ((bus.d_md || bus.d_mfmt) && e_busy));
    e_issue = bus.d_valid && !e_stall && !bus.flush;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int age = 0; age < 3; age++) begin
      m_valid[age] = 1'b0;
      m_wr[age]    = 1'b0;
      m_a3[age]    = 5'd0;
      m_t0[age]    = 0;
    end
    md_ready = cyc;
  endtask

  task automatic model_update();
    model_eval();
    if (bus.w_regwrite && bus.w_a3 != 5'd0) m_regs[bus.w_a3] = bus.w_wd;
    if (bus.flush) begin
      for (int age = 0; age < 3; age++) m_valid[age] = 1'b0;
      if (md_ready > cyc + 1) md_ready = cyc + 1;
    end else begin
      for (int age = 2; age > 0; age--) begin
        m_valid[age] = m_valid[age-1];
        m_wr[age]    = m_wr[age-1];
        m_a3[age]    = m_a3[age-1];
        m_t0[age]    = m_t0[age-1];
      end
      m_valid[0] = e_issue;
      m_wr[0]    = bus.d_regwrite && bus.d_a3 != 5'd0;
      m_a3[0]    = bus.d_a3;
      m_t0[0]    = int'(bus.d_tnew);
      if (e_issue && bus.d_md) md_ready = cyc + 1 + (bus.d_md_div ? 10 : 5);
    end
    cyc++;
  endtask

  task automatic check_model();
    model_eval();
    check_output("rs_value", bus.rs_value, e_rs_val);
    check_output("rt_value", bus.rt_value, e_rt_val);
    check_output("fwd_rs_sel", 32'(bus.fwd_rs_sel), 32'(e_fwd_rs));
    check_output("fwd_rt_sel", 32'(bus.fwd_rt_sel), 32'(e_fwd_rt));
    check_output("stall", 32'(bus.stall), 32'(e_stall));
    check_output("md_busy", 32'(bus.md_busy), 32'(e_busy));
  endtask

  task automatic apply_stimulus();
    bus.d_valid    = 1'b0;
    bus.d_rs       = 5'd0;
    bus.d_rt       = 5'd0;
    bus.d_tuse_rs  = 3'd7;
    bus.d_tuse_rt  = 3'd7;
    bus.d_regwrite = 1'b0;
    bus.d_a3       = 5'd0;
    bus.d_tnew     = 3'd0;
    bus.d_md       = 1'b0;
    bus.d_md_div   = 1'b0;
    bus.d_mfmt     = 1'b0;
    bus.flush      = 1'b0;
    bus.w_regwrite = 1'b0;
    bus.w_a3       = 5'd0;
    bus.w_wd       = 32'd0;
  endtask

  task automatic settle_check();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain(input int n);
    apply_stimulus();
    repeat (n) begin
      settle_check();
      advance();
    end
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus();
    model_reset();
    #1;
    check_output("reset_stall", 32'(bus.stall), 32'd0);
    check_output("reset_md_busy", 32'(bus.md_busy), 32'd0);
    check_output("reset_fwd_rs", 32'(bus.fwd_rs_sel), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      bus.d_rs = 5'(i);
      bus.d_rt = 5'(31 - i);
      settle_check();
      check_output("reset_read_rs", bus.rs_value, 32'd0);
      check_output("reset_read_rt", bus.rt_value, 32'd0);
      advance();
    end

    apply_stimulus();
    bus.w_regwrite = 1'b1;
    bus.w_a3 = 5'd0;
    bus.w_wd = 32'hFFFF_FFFF;
    settle_check();
    check_output("r0_write_same", bus.rs_value, 32'd0);
    advance();
    bus.w_regwrite = 1'b0;
    settle_check();
    check_output("r0_write_after", bus.rs_value, 32'd0);
    advance();

    bus.d_rs = 5'd5;
    bus.w_regwrite = 1'b1;
    bus.w_a3 = 5'd5;
    bus.w_wd = 32'h1234;
    settle_check();
    check_output("w_bypass_rs", bus.rs_value, 32'h1234);
    advance();
    bus.w_regwrite = 1'b0;
    settle_check();
    check_output("r5_stored", bus.rs_value, 32'h1234);
    advance();

    apply_stimulus();
    bus.d_valid = 1'b1;
    bus.d_regwrite = 1'b1;
    bus.d_a3 = 5'd8;
    bus.d_tnew = 3'd1;
    settle_check();
    check_output("alu_issue_stall", 32'(bus.stall), 32'd0);
    advance();
    apply_stimulus();
    bus.d_valid = 1'b1;
    bus.d_rs = 5'd8;
    bus.d_tuse_rs = 3'd0;
    settle_check();
    check_output("alu_dep_stall", 32'(bus.stall), 32'd1);
    advance();
    settle_check();
    check_output("alu_dep_release", 32'(bus.stall), 32'd0);
    check_output("alu_dep_fwd_m", 32'(bus.fwd_rs_sel), 32'd2);
    advance();
    drain(3);

    bus.d_valid = 1'b1;
    bus.d_regwrite = 1'b1;
    bus.d_a3 = 5'd9;
    bus.d_tnew = 3'd2;
    settle_check();
    advance();
    apply_stimulus();
    bus.d_valid = 1'b1;
    bus.d_rt = 5'd9;
    bus.d_tuse_rt = 3'd1;
    settle_check();
    check_output("load_use_stall", 32'(bus.stall), 32'd1);
    advance();
    settle_check();
    check_output("load_use_release", 32'(bus.stall), 32'd0);
    check_output("load_use_fwd_rt", 32'(bus.fwd_rt_sel), 32'd0);
    advance();
    drain(3);

    bus.d_valid = 1'b1;
    bus.d_regwrite = 1'b1;
    bus.d_a3 = 5'd9;
    bus.d_tnew = 3'd3;
    settle_check();
    advance();
    bus.d_tnew = 3'd1;
    settle_check();
    advance();
    apply_stimulus();
    bus.d_valid = 1'b1;
    bus.d_rt = 5'd9;
    bus.d_tuse_rt = 3'd1;
    settle_check();
    check_output("youngest_only_stall", 32'(bus.stall), 32'd0);
    advance();
    bus.d_tuse_rt = 3'd0;
    settle_check();
    check_output("youngest_fwd_rt", 32'(bus.fwd_rt_sel), 32'd2);
    check_output("youngest_fwd_stall", 32'(bus.stall), 32'd0);
    advance();
    drain(3);

    for (int lat_sel = 0; lat_sel < 2; lat_sel++) begin
      apply_stimulus();
      bus.d_valid = 1'b1;
      bus.d_md = 1'b1;
      bus.d_md_div = (lat_sel == 1);
      settle_check();
      check_output("md_issue_stall", 32'(bus.stall), 32'd0);
      advance();
      apply_stimulus();
      bus.d_valid = 1'b1;
      bus.d_mfmt = 1'b1;
      repeat ((lat_sel == 1) ? 10 : 5) begin
        settle_check();
        check_output("mf_wait_stall", 32'(bus.stall), 32'd1);
        check_output("mf_wait_busy", 32'(bus.md_busy), 32'd1);
        advance();
      end
      settle_check();
      check_output("mf_go_stall", 32'(bus.stall), 32'd0);
      check_output("mf_go_busy", 32'(bus.md_busy), 32'd0);
      advance();
      drain(2);
    end

    bus.d_valid = 1'b1;
    bus.d_md = 1'b1;
    bus.d_md_div = 1'b1;
    settle_check();
    advance();
    apply_stimulus();
    bus.d_valid = 1'b1;
    bus.d_regwrite = 1'b1;
    bus.d_a3 = 5'd10;
    bus.d_tnew = 3'd2;
    settle_check();
    check_output("load_during_div", 32'(bus.stall), 32'd0);
    advance();
    apply_stimulus();
    bus.d_valid = 1'b1;
    bus.d_rs = 5'd10;
    bus.d_tuse_rs = 3'd0;
    bus.d_mfmt = 1'b1;
    bus.flush = 1'b1;
    settle_check();
    check_output("flush_stall_forced", 32'(bus.stall), 32'd0);
    check_output("flush_busy_before", 32'(bus.md_busy), 32'd1);
    advance();
    bus.flush = 1'b0;
    settle_check();
    check_output("post_flush_stall", 32'(bus.stall), 32'd0);
    check_output("post_flush_busy", 32'(bus.md_busy), 32'd0);
    advance();
    drain(2);

    bus.d_valid = 1'b1;
    bus.d_md = 1'b1;
    settle_check();
    advance();
    apply_stimulus();
    bus.d_valid = 1'b1;
    bus.d_mfmt = 1'b1;
    bus.d_rs = 5'd5;
    settle_check();
    check_output("pre_reset_stall", 32'(bus.stall), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_output("async_reset_stall", 32'(bus.stall), 32'd0);
    check_output("async_reset_busy", 32'(bus.md_busy), 32'd0);
    check_output("async_reset_rs", bus.rs_value, 32'd0);
    check_model();
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int n = 0; n < 600; n++) begin
      bus.d_valid    = ($urandom_range(0, 3) != 0);
      bus.d_rs       = 5'($urandom_range(0, 7));
      bus.d_rt       = 5'($urandom_range(0, 7));
      bus.d_tuse_rs  = 3'($urandom_range(0, 3));
      bus.d_tuse_rt  = 3'($urandom_range(0, 3));
      bus.d_regwrite = ($urandom_range(0, 1) != 0);
      bus.d_a3       = 5'($urandom_range(0, 7));
      bus.d_tnew     = 3'($urandom_range(0, 3));
      bus.d_md       = ($urandom_range(0, 9) == 0);
      bus.d_md_div   = ($urandom_range(0, 1) != 0);
      bus.d_mfmt     = ($urandom_range(0, 7) == 0);
      bus.flush      = ($urandom_range(0, 31) == 0);
      bus.w_regwrite = ($urandom_range(0, 1) != 0);
      bus.w_a3       = 5'($urandom_range(0, 7));
      bus.w_wd       = $urandom;
      settle_check();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
